gcd_result_display: RTL and testbench
=====================================

// Module: gcd_result_display
// PURPOSE
//   Downstream of the GCD controller/datapath. Captures the GCD result when the controller pulses d_ld,
//   converts it to 4-digit BCD by sequential shift-add-3 (one bit per clock), then drives a
//   time-multiplexed 4-digit common-anode seven-segment display. Display stays dark until done=1.
// PARAMETERS
//   WIDTH        8      result width in bits, legal 1..13 (max 8191 fits 4 BCD digits)
//   REFRESH_DIV  50000  clocks each digit is lit before the scan advances, legal >=1
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   reset      in   1       asynchronous, active-low; 0 clears all state immediately
//   d_ld       in   1       result-load strobe from controller; may be held high many cycles
//   done       in   1       controller done flag; display enabled only while 1
//   result     in   WIDTH   GCD value from datapath, sampled on d_ld rising edge
//   busy       out  1       1 while a BCD conversion is in progress
//   bcd        out  16      {thousands,hundreds,tens,ones} of last completed conversion
//   bcd_valid  out  1       1 once a conversion completes, until next capture
//   an         out  4       digit anodes, active-low, an[0] = ones digit
//   seg        out  7       {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//   - Reset (reset=0, async): busy=0, bcd=16'h0000, bcd_valid=0, an=4'b1111, seg=7'b1111111,
//     FSM=IDLE, shift count=0, refresh counter=0, digit index=0, d_ld history=0.
//   - Edge detect: d_ld_q registers d_ld every cycle; capture event = d_ld & ~d_ld_q.
//   - FSM IDLE: on capture event at edge N -> load shift reg=result, scratch=0, count=0,
//     busy=1, bcd_valid=0, state CONV. No event -> stay.
//   - FSM CONV: each edge, every scratch nibble >=5 gets +3, then {scratch,shift} shifts left 1; count++.
//     On the WIDTH-th shift (edge N+WIDTH): bcd<=final scratch, bcd_valid=1, busy=0 -> IDLE.
//     Latency: bcd_valid rises exactly WIDTH clocks after the capture edge.
//   - Capture events during CONV are ignored (not queued); d_ld_q still tracks, so a level held
//     high across completion does not retrigger.
//   - Value range: result < 10^4 always for WIDTH<=13; no saturation logic.
//   - Scan: refresh counter counts 0..REFRESH_DIV-1 free-running; at terminal count -> 0 and
//     digit index advances 0,1,2,3,0 (wrap). Runs regardless of done/bcd_valid.
//   - Outputs registered: an = ~(1<<digit index) when done & bcd_valid, else 4'b1111.
//     seg = decode(bcd nibble[digit index]) when lit, else 7'b1111111.
//   - Decode 0-9: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,
//     0000000,0010000; nibbles 10-15 (unreachable) -> 7'b1111111.
//   - During CONV, bcd_valid=0 -> display dark; bcd holds old value until overwritten.
//   - done falling: display dark next edge; bcd/bcd_valid unaffected.
//   - reset mid-conversion: conversion abandoned, all outputs to reset values at once.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digit k (k=3..1) blanked (its anode held 1, seg=7'b1111111)
//     when it and all higher digits are zero; ones digit always lit (value 0 shows "0").
//   Not defined: all four digits lit whenever display enabled, leading zeros shown as "0".
// TESTING
//   1 reset=0 mid-run, any inputs -> an=1111, seg=1111111, bcd=0, bcd_valid=0, busy=0 within same cycle.
//   2 WIDTH=8, result=8'd6, d_ld 1-cycle pulse -> busy 8 cycles, then bcd=16'h0006, bcd_valid=1.
//   3 result=8'd255, d_ld held high 20 cycles -> exactly one conversion, bcd=16'h0255.
//   4 second d_ld rise 3 cycles into a conversion with result=8'd9 -> ignored; bcd from first value.
//   5 REFRESH_DIV=4, done=1, bcd=16'h1234 -> an cycles 1110,1101,1011,0111 each 4 clocks;
//     seg 0011001,0110000,0100100,1111001 respectively; done=0 -> an=1111 next edge.
//   6 bcd=16'h0007: without LEADING_ZERO_BLANK_EN all digits lit (seg 1000000 x3, 1111000);
//     with LEADING_ZERO_BLANK_EN only an[0] ever goes low.

Source files
------------

// File: rtl/gcd_result_display.sv
// ============================================================================
// gcd_result_display
//
// Purpose:
//   Captures the GCD result when the controller raises d_ld and converts it to
//   four BCD digits with a sequential shift-add-3 (double dabble) engine. The
//   engine processes one result bit per clock. The last completed BCD value is
//   shown on a time-multiplexed 4-digit common-anode seven-segment display. The
//   display stays dark unless done=1 and a completed conversion is available.
//
// Parameters:
//   WIDTH        result width in bits, 1..13 (8191 still fits four BCD digits)
//   REFRESH_DIV  number of clocks each digit stays lit before the scan advances
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-low; 0 clears all state immediately
//   d_ld       result-load strobe; only its rising edge starts a conversion
//   done       controller done flag; the display is enabled only while it is 1
//   result     GCD value, sampled on the d_ld rising edge
//   busy       1 while a conversion is in progress
//   bcd        {thousands, hundreds, tens, ones} of the last completed conversion
//   bcd_valid  1 from conversion completion until the next capture
//   an         digit anodes, active-low; an[0] drives the ones digit
//   seg        segments {g,f,e,d,c,b,a}, active-low
//
// Configuration:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (thousands down to
//                          tens) are blanked. The ones digit is always lit.
// ============================================================================
module gcd_result_display #(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_ld,
    input  logic             done,
    input  logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [15:0]      bcd,
    output logic             bcd_valid,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int              RW           = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0]   REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [3:0]      COUNT_LAST   = 4'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t             r_state, w_state_next;
    logic               r_d_ld_q;
    logic [WIDTH-1:0]   r_shift, w_shift_next;
    logic [15:0]        r_scratch, w_scratch_next;
    logic [3:0]         r_count, w_count_next;
    logic               r_busy, w_busy_next;
    logic [15:0]        r_bcd, w_bcd_next;
    logic               r_bcd_valid, w_bcd_valid_next;

    logic               w_capture;
    logic [15:0]        w_scratch_adj;
    logic [15:0]        w_scratch_shl;

    assign w_capture = d_ld & ~r_d_ld_q;

    // Add 3 to every BCD nibble of 5 or more before the shift. After the
    // shift the nibble then carries correctly into the next decimal digit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_scratch_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                                            ? r_scratch[gi*4 +: 4] + 4'd3
                                            : r_scratch[gi*4 +: 4];
        end
    endgenerate

    // Shift the MSB of the binary operand into the BCD scratch register.
    // The scratch MSB is discarded; it stays zero because results fit 4 digits.
    assign w_scratch_shl = (w_scratch_adj << 1) | 16'(r_shift[WIDTH-1]);

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_scratch_next   = r_scratch;
        w_count_next     = r_count;
        w_busy_next      = r_busy;
        w_bcd_next       = r_bcd;
        w_bcd_valid_next = r_bcd_valid;

        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_shift_next     = result;
                    w_scratch_next   = 16'h0000;
                    w_count_next     = 4'd0;
                    w_busy_next      = 1'b1;
                    w_bcd_valid_next = 1'b0;
                    w_state_next     = S_CONV;
                end
            end
            S_CONV: begin
                // Capture events here are dropped. r_d_ld_q still follows
                // d_ld, so a level held across completion cannot retrigger.
                w_scratch_next = w_scratch_shl;
                w_shift_next   = r_shift << 1;
                w_count_next   = r_count + 4'd1;
                if (r_count == COUNT_LAST) begin
                    w_bcd_next       = w_scratch_shl;
                    w_bcd_valid_next = 1'b1;
                    w_busy_next      = 1'b0;
                    w_state_next     = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_d_ld_q    <= 1'b0;
            r_shift     <= '0;
            r_scratch   <= 16'h0000;
            r_count     <= 4'd0;
            r_busy      <= 1'b0;
            r_bcd       <= 16'h0000;
            r_bcd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_d_ld_q    <= d_ld;
            r_shift     <= w_shift_next;
            r_scratch   <= w_scratch_next;
            r_count     <= w_count_next;
            r_busy      <= w_busy_next;
            r_bcd       <= w_bcd_next;
            r_bcd_valid <= w_bcd_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [RW-1:0]  r_refresh;
    logic [1:0]     r_digit;
    logic [3:0]     r_an;
    logic [6:0]     r_seg;
    logic [3:0]     w_nibble;
    logic [3:0]     w_blank;
    logic           w_lit;
    logic [6:0]     w_seg_dec;

    // The refresh counter and digit index run freely. The scan timing does
    // not depend on done or bcd_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_digit   <= 2'd0;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= '0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_refresh <= r_refresh + RW'(1);
        end
    end

    assign w_nibble = r_bcd[r_digit*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a digit when it and every higher digit are zero. The ones digit
    // is never blanked, so a value of 0 still shows "0".
    logic [3:1] w_zero;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_zero
            assign w_zero[gi] = (r_bcd[gi*4 +: 4] == 4'd0);
        end
    endgenerate
    assign w_blank[3] = w_zero[3];
    assign w_blank[2] = w_zero[2] & w_blank[3];
    assign w_blank[1] = w_zero[1] & w_blank[2];
    assign w_blank[0] = 1'b0;
`else
    assign w_blank = 4'b0000;
`endif

    assign w_lit = done & r_bcd_valid & ~w_blank[r_digit];

    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_nibble)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else if (w_lit) begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_dec;
        end else begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end
    end

    assign busy      = r_busy;
    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule

// File: tb/tb_gcd_result_display.sv
// ============================================================================
// tb_gcd_result_display
//
// Scoreboard bench for gcd_result_display with WIDTH=8 and REFRESH_DIV=4.
// A cycle-level reference model tracks which captures are accepted. It derives
// expected BCD digits with decimal division and the scan position from the
// number of elapsed clocks. Each accepted capture pushes its value into a
// queue. The monitor pops an entry when bcd_valid rises and compares it.
// The monitor also compares every output against the model after each edge.
// ============================================================================
module tb_gcd_result_display;

    localparam int WIDTH = 8;
    localparam int RD    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             d_ld = 1'b0;
    logic             done = 1'b0;
    logic [WIDTH-1:0] result = '0;
    logic             busy;
    logic [15:0]      bcd;
    logic             bcd_valid;
    logic [3:0]       an;
    logic [6:0]       seg;

    gcd_result_display #(.WIDTH(WIDTH), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_ld      (d_ld),
        .done      (done),
        .result    (result),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int n_conv = 0;
    bit finishing = 1'b0;
    bit final_done = 1'b0;

    // Reference model state
    int         m_val = 0;
    bit         m_valid = 1'b0;
    int         m_left = 0;
    int         m_pending = 0;
    bit         m_dq = 1'b0;
    int         m_k = 0;
    logic [3:0] m_an = 4'hF;
    logic [6:0] m_seg = 7'h7F;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int digit_of(input int v, input int pos);
        return (v / pow10(pos)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(digit_of(v, 3)), 4'(digit_of(v, 2)), 4'(digit_of(v, 1)), 4'(digit_of(v, 0))};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: updates at the same instants as the DUT state
    always @(posedge clk or negedge reset) begin : model
        int idx;
        bit lit;
        if (!reset) begin
            m_val   = 0;
            m_valid = 1'b0;
            m_left  = 0;
            m_dq    = 1'b0;
            m_k     = 0;
            m_an    = 4'hF;
            m_seg   = 7'h7F;
            exp_q.delete();
        end else begin
            // The display output after this edge depends on the state before it
            idx = (m_k / RD) % 4;
            lit = done && m_valid;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && m_val < pow10(idx)) lit = 1'b0;
`endif
            m_an  = 4'hF;
            m_seg = 7'h7F;
            if (lit) begin
                m_an[idx] = 1'b0;
                m_seg     = seg_of(digit_of(m_val, idx));
            end
            // A conversion takes WIDTH clocks. Captures are ignored while one runs.
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_val   = m_pending;
                end
            end else if (d_ld && !m_dq) begin
                m_pending = int'(result);
                m_left    = WIDTH;
                m_valid   = 1'b0;
                exp_q.push_back(m_pending);
            end
            m_dq = d_ld;
            m_k++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks every output shortly after each clock edge and each
    // reset assertion. It pops the scoreboard when bcd_valid rises.
    initial begin : monitor
        bit prev_valid;
        int v;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (!reset) chk("reset_bcd", int'(bcd), 0);
            chk("an", int'(an), int'(m_an));
            chk("seg", int'(seg), int'(m_seg));
            chk("busy", int'(busy), int'(m_left > 0));
            chk("bcd_valid", int'(bcd_valid), int'(m_valid));
            chk("bcd_hold", int'(bcd), int'(to_bcd(m_val)));
            if (bcd_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", 1, 0);
                end else begin
                    v = exp_q.pop_front();
                    chk("sb_bcd", int'(bcd), int'(to_bcd(v)));
                    n_conv++;
                    $display("conversion result=%0d bcd=%04h expected=%04h", v, bcd, to_bcd(v));
                end
            end
            prev_valid = bcd_valid;
            if (finishing && !final_done) begin
                chk("sb_drained", exp_q.size(), 0);
                chk("conversions_seen", int'(n_conv >= 8), 1);
                final_done = 1'b1;
            end
        end
    end

    task automatic pulse(input int value, input int hold);
        result = WIDTH'(value);
        d_ld   = 1'b1;
        repeat (hold) @(negedge clk);
        d_ld   = 1'b0;
    endtask

    initial begin : driver
        int small_vals[4] = '{0, 10, 99, 128};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single-cycle pulse of 6, then a lit display
        @(negedge clk);
        done = 1'b1;
        pulse(6, 1);
        repeat (30) @(negedge clk);

        // d_ld held high for 20 cycles: exactly one conversion
        pulse(255, 20);
        repeat (20) @(negedge clk);

        // Second rising edge 3 cycles into a conversion is ignored
        pulse(200, 1);
        repeat (2) @(negedge clk);
        pulse(9, 1);
        repeat (20) @(negedge clk);

        // done falling darkens the display; bcd is kept
        done = 1'b0;
        repeat (6) @(negedge clk);
        done = 1'b1;

        // Small value exercises leading digits
        pulse(7, 1);
        repeat (30) @(negedge clk);
        foreach (small_vals[i]) begin
            pulse(small_vals[i], 2);
            repeat (24) @(negedge clk);
        end

        // Asynchronous reset in the middle of a conversion
        pulse(123, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        done  = 1'b1;
        repeat (4) @(negedge clk);

        // Randomized captures, holds, gaps and done levels
        repeat (40) begin
            done = ($urandom_range(0, 3) != 0);
            pulse(int'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        finishing = 1'b1;
        for (int i = 0; i < 5 && !final_done; i++) @(negedge clk);
        if (!final_done) begin
            $display("FAIL monitor_final: actual=0 required=1");
            $fatal(1, "monitor did not complete final checks");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
